// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and types for the two-requester AXI-lite read arbiter.
// Requester IDs double as the payload of the in-order response routing FIFO.
package axi_rd_arbiter_pkg;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Instruction fetches are always full 8-byte beats
  localparam logic [2:0] IFU_ARSIZE = 3'b011;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/axi_rd_arbiter_order.sv
// In-order FIFO of 1-bit requester IDs, one entry per accepted AR.
// The head names the destination of the next R beat.
module arb_order_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  din,
  output logic                  dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                  mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin AR arbiter between IFU and LSU onto one AXI-lite read port,
// with in-order R steering driven by a FIFO of granted requester IDs.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int OUTST_LOG2 = 3,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  input  logic [ADDR_W-1:0]     ifu_araddr,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  output logic [1:0]            ifu_rresp,
  output logic [DATA_W-1:0]     ifu_rdata,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic [2:0]            lsu_arsize,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  output logic [1:0]            lsu_rresp,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [2:0]            m_arsize,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [1:0]            m_rresp,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic [OUTST_LOG2:0]   outst_cnt,
  output logic                  err_orphan_r
);

  arb_state_t state_reg, state_next;
  logic       lock_id_reg, lock_id_next;
  logic       rr_prio_reg, rr_prio_next;
  logic       err_orphan_reg;

  logic winner;
  logic sel;
  logic sel_arvalid;
  logic ar_hs;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic r_pop;

  // AR arbitration: a lone requester wins, ties go to rr_prio
  always_comb begin
    winner = rr_prio_reg;
    if (ifu_arvalid && !lsu_arvalid) begin
      winner = REQ_IFU;
    end else if (lsu_arvalid && !ifu_arvalid) begin
      winner = REQ_LSU;
    end
  end

  assign sel         = (state_reg == ARB_LOCKED) ? lock_id_reg : winner;
  assign sel_arvalid = (sel == REQ_IFU) ? ifu_arvalid : lsu_arvalid;
  assign m_arvalid   = sel_arvalid & ~fifo_full;
  assign ar_hs       = m_arvalid & m_arready;
  assign m_araddr    = (sel == REQ_IFU) ? ifu_araddr : lsu_araddr;
  assign m_arsize    = (sel == REQ_IFU) ? IFU_ARSIZE : lsu_arsize;
  assign ifu_arready = ar_hs & (sel == REQ_IFU);
  assign lsu_arready = ar_hs & (sel == REQ_LSU);

  // Lock holds the stalled grant until its handshake or the requester withdraws
  always_comb begin
    state_next   = state_reg;
    lock_id_next = lock_id_reg;
    case (state_reg)
      ARB_FREE: begin
        if (m_arvalid && !m_arready) begin
          state_next   = ARB_LOCKED;
          lock_id_next = sel;
        end
      end
      ARB_LOCKED: begin
        if (ar_hs || !sel_arvalid) begin
          state_next = ARB_FREE;
        end
      end
      default: state_next = ARB_FREE;
    endcase
  end

  assign rr_prio_next = ar_hs ? ~sel : rr_prio_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB_FREE;
      lock_id_reg    <= REQ_IFU;
      rr_prio_reg    <= REQ_LSU;
      err_orphan_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lock_id_reg <= lock_id_next;
      rr_prio_reg <= rr_prio_next;
      if (m_rvalid && fifo_empty) begin
        err_orphan_reg <= 1'b1;
      end
    end
  end

  arb_order_fifo #(
    .DEPTH_LOG2 (OUTST_LOG2)
  ) u_order_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ar_hs),
    .pop   (r_pop),
    .din   (sel),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outst_cnt)
  );

  // With nothing outstanding, beats are absorbed and flagged rather than stalled
  assign m_rready   = fifo_empty ? 1'b1 :
                      ((fifo_head == REQ_IFU) ? ifu_rready : lsu_rready);
  assign ifu_rvalid = m_rvalid & ~fifo_empty & (fifo_head == REQ_IFU);
  assign lsu_rvalid = m_rvalid & ~fifo_empty & (fifo_head == REQ_LSU);
  assign r_pop      = m_rvalid & m_rready & ~fifo_empty;

  assign ifu_rresp    = m_rresp;
  assign ifu_rdata    = m_rdata;
  assign lsu_rresp    = m_rresp;
  assign lsu_rdata    = m_rdata;
  assign err_orphan_r = err_orphan_reg;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a queue-based reference model checked every
// cycle on the falling edge, plus literal expectations for each scenario.
module tb_axi_rd_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [AW-1:0] ifu_araddr;
  logic [1:0]    ifu_rresp;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [AW-1:0] lsu_araddr;
  logic [2:0]    lsu_arsize;
  logic [1:0]    lsu_rresp;
  logic [DW-1:0] lsu_rdata;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0] m_araddr;
  logic [2:0]    m_arsize;
  logic [1:0]    m_rresp;
  logic [DW-1:0] m_rdata;
  logic [3:0]    outst_cnt;
  logic          err_orphan_r;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.OUTST_LOG2(3), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .outst_cnt(outst_cnt), .err_orphan_r(err_orphan_r)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding requesters in acceptance order, pending grant, priority
  bit ord[$];
  bit md_lock, md_lock_id, md_prio, md_orph;
  bit e_s, e_selv, e_mav, e_hs, e_mrready, e_irv, e_lrv, e_pop, e_orph;

  task automatic clear_model();
    ord.delete();
    md_lock = 0; md_lock_id = 0; md_prio = 1; md_orph = 0;
  endtask

  initial begin
    clear_model();
    forever begin
      @(negedge clk);
      if (!rst_n) clear_model();
      if (md_lock) e_s = md_lock_id;
      else if (ifu_arvalid && !lsu_arvalid) e_s = 0;
      else if (lsu_arvalid && !ifu_arvalid) e_s = 1;
      else e_s = md_prio;
      e_selv = e_s ? lsu_arvalid : ifu_arvalid;
      e_mav  = e_selv && (ord.size() < 8);
      e_hs   = e_mav && m_arready;
      e_irv = 0; e_lrv = 0; e_mrready = 1;
      if (ord.size() > 0) begin
        e_mrready = ord[0] ? lsu_rready : ifu_rready;
        e_irv = m_rvalid && !ord[0];
        e_lrv = m_rvalid && ord[0];
      end
      e_pop  = m_rvalid && e_mrready && (ord.size() > 0);
      e_orph = m_rvalid && (ord.size() == 0);

      chk("m_arvalid", m_arvalid, e_mav);
      chk("ifu_arready", ifu_arready, e_hs && !e_s);
      chk("lsu_arready", lsu_arready, e_hs && e_s);
      if (e_mav) begin
        chk("m_araddr", m_araddr, e_s ? lsu_araddr : ifu_araddr);
        chk("m_arsize", m_arsize, e_s ? lsu_arsize : 3'b011);
      end
      chk("m_rready", m_rready, e_mrready);
      chk("ifu_rvalid", ifu_rvalid, e_irv);
      chk("lsu_rvalid", lsu_rvalid, e_lrv);
      if (e_irv) chk("ifu_rdata", ifu_rdata, m_rdata);
      if (e_irv) chk("ifu_rresp", ifu_rresp, m_rresp);
      if (e_lrv) chk("lsu_rdata", lsu_rdata, m_rdata);
      if (e_lrv) chk("lsu_rresp", lsu_rresp, m_rresp);
      chk("outst_cnt", outst_cnt, ord.size());
      chk("err_orphan_r", err_orphan_r, md_orph);

      @(posedge clk);
      if (!rst_n) begin
        clear_model();
      end else begin
        if (e_pop) void'(ord.pop_front());
        if (e_hs) begin
          ord.push_back(e_s);
          md_prio = !e_s;
        end
        if (e_mav && !m_arready) begin
          md_lock = 1; md_lock_id = e_s;
        end else if (md_lock && (e_hs || !e_selv)) begin
          md_lock = 0;
        end
        if (e_orph) md_orph = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      m_rvalid = 1'b1;
      m_rdata  = 64'hD000_0000_0000_0000 | 64'(i);
      m_rresp  = i[1:0];
    end
    step();
    m_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_arvalid = 0; ifu_araddr = '0; ifu_rready = 1;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_arsize = 3'b010; lsu_rready = 1;
    m_arready = 0; m_rvalid = 0; m_rresp = 2'b00; m_rdata = '0;
    step();
    chk("rst_m_rready", m_rready, 1);
    chk("rst_outst", outst_cnt, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    step();
    rst_n = 1'b1;

    // Single IFU fetch
    step();
    ifu_arvalid = 1; ifu_araddr = 64'h8000_0000; m_arready = 1;
    #1;
    chk("t1_ifu_arready", ifu_arready, 1);
    chk("t1_m_arsize", m_arsize, 3'b011);
    step();
    ifu_arvalid = 0; m_rvalid = 1; m_rdata = 64'h1122334455667788;
    #1;
    chk("t1_outst_1", outst_cnt, 1);
    chk("t1_ifu_rvalid", ifu_rvalid, 1);
    chk("t1_ifu_rdata", ifu_rdata, 64'h1122334455667788);
    chk("t1_lsu_rvalid", lsu_rvalid, 0);
    step();
    m_rvalid = 0;
    #1;
    chk("t1_outst_0", outst_cnt, 0);

    // Both valid: grants alternate starting with LSU
    step();
    ifu_arvalid = 1; ifu_araddr = 64'h100;
    lsu_arvalid = 1; lsu_araddr = 64'h2000; lsu_arsize = 3'b010;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      #1;
      chk("t2_lsu_grant", lsu_arready, (i % 2) == 0);
      chk("t2_ifu_grant", ifu_arready, (i % 2) == 1);
      chk("t2_m_araddr", m_araddr, ((i % 2) == 0) ? 64'h2000 : 64'h100);
    end
    step();
    ifu_arvalid = 0; lsu_arvalid = 0;
    m_rvalid = 1; m_rdata = 64'hA0; lsu_rready = 0;
    #1;
    chk("t2_outst_4", outst_cnt, 4);
    chk("t2_bp_m_rready", m_rready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      lsu_rready = 1; m_rdata = 64'hA0 + 64'(i);
      #1;
      chk("t2_r_lsu", lsu_rvalid, (i % 2) == 0);
      chk("t2_r_ifu", ifu_rvalid, (i % 2) == 1);
    end
    step();
    m_rvalid = 0;
    #1;
    chk("t2_outst_0", outst_cnt, 0);

    // LSU held under backpressure while IFU (now priority) waits
    step();
    lsu_arvalid = 1; lsu_araddr = 64'h3000; m_arready = 1;
    #1;
    chk("t3_lsu_first", lsu_arready, 1);
    step();
    lsu_araddr = 64'h3008; m_arready = 0;
    #1;
    chk("t3_m_arvalid", m_arvalid, 1);
    step();
    ifu_arvalid = 1; ifu_araddr = 64'h140;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      chk("t3_hold_addr", m_araddr, 64'h3008);
      chk("t3_hold_valid", m_arvalid, 1);
      chk("t3_ifu_wait", ifu_arready, 0);
    end
    step();
    m_arready = 1;
    #1;
    chk("t3_lsu_hs", lsu_arready, 1);
    step();
    lsu_arvalid = 0;
    #1;
    chk("t3_ifu_hs", ifu_arready, 1);
    chk("t3_ifu_addr", m_araddr, 64'h140);
    step();
    ifu_arvalid = 0;
    #1;
    chk("t3_outst_3", outst_cnt, 3);
    drain(3);

    // Fill the FIFO with IFU fetches
    step();
    ifu_arvalid = 1; m_arready = 1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      ifu_araddr = 64'h1000 + 64'(i * 8);
      #1;
      chk("t4_accept", ifu_arready, 1);
    end
    step();
    ifu_araddr = 64'h1040;
    #1;
    chk("t4_full_arready", ifu_arready, 0);
    chk("t4_full_arvalid", m_arvalid, 0);
    chk("t4_outst_8", outst_cnt, 8);
    step();
    m_rvalid = 1; m_rdata = 64'hF1;
    #1;
    chk("t4_pop_no_push", ifu_arready, 0);
    chk("t4_pop_rvalid", ifu_rvalid, 1);
    step();
    m_rvalid = 0;
    #1;
    chk("t4_after_pop", ifu_arready, 1);
    chk("t4_outst_7", outst_cnt, 7);
    step();
    ifu_arvalid = 0;
    #1;
    chk("t4_outst_8b", outst_cnt, 8);
    drain(8);

    // IFU locked then withdraws
    step();
    ifu_arvalid = 1; ifu_araddr = 64'h2000_0000; m_arready = 0;
    #1;
    chk("t5_locked_valid", m_arvalid, 1);
    step();
    ifu_arvalid = 0; lsu_arvalid = 1; lsu_araddr = 64'h4000; m_arready = 1;
    #1;
    chk("t5_drop_arvalid", m_arvalid, 0);
    chk("t5_drop_lsu", lsu_arready, 0);
    step();
    #1;
    chk("t5_lsu_grant", lsu_arready, 1);
    chk("t5_lsu_addr", m_araddr, 64'h4000);
    step();
    lsu_arvalid = 0;
    drain(1);

    // Orphan beat, sticky flag, reset mid-transaction
    step();
    m_rvalid = 1; m_rdata = 64'hDEAD;
    #1;
    chk("t6_m_rready", m_rready, 1);
    chk("t6_ifu_rvalid", ifu_rvalid, 0);
    chk("t6_lsu_rvalid", lsu_rvalid, 0);
    step();
    m_rvalid = 0;
    #1;
    chk("t6_orphan_set", err_orphan_r, 1);
    step();
    lsu_arvalid = 1;
    #1;
    chk("t6_orphan_sticky", err_orphan_r, 1);
    step();
    lsu_arvalid = 0;
    #1;
    chk("t6_outst_1", outst_cnt, 1);
    step();
    rst_n = 0;
    #1;
    chk("t6_rst_orphan", err_orphan_r, 0);
    chk("t6_rst_outst", outst_cnt, 0);
    step();
    rst_n = 1; m_rvalid = 1;
    step();
    m_rvalid = 0;
    #1;
    chk("t6_late_orphan", err_orphan_r, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
